// File: rtl/usb_pkg.sv
// Shared PID encodings, controller state set and default handshake timeout.
package usb_pkg;

    // 18 full-speed bit times at 9 clk cycles per bit
    localparam int TIMEOUT_CYCLES_DEFAULT = 162;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_IN    = 3'd1,
        RX_OUT   = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6,
        RX_STALL = 3'd7
    } rx_pid_e;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_pid_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_SEND_HS,
        ST_SEND_DATA,
        ST_TX_WAIT,
        ST_WAIT_ACK
    } state_e;

    // DATA PID that carries a given toggle value
    function automatic tx_pid_e data_pid(input logic toggle);
        return toggle ? TX_DATA1 : TX_DATA0;
    endfunction

endpackage

// File: rtl/usb_timeout_counter.sv
// Saturating 8-bit handshake wait counter with a terminal compare.
module usb_timeout_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic [7:0] count,
    output logic       expired
);

    // Count enabled cycles, hold at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// USB full-speed device transaction controller: token decode, handshake
// generation, data toggle tracking and host-handshake timeout.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | waiting for an IN or OUT token
// ST_WAIT_DATA | OUT token seen, waiting for the DATA0/1 packet
// ST_SEND_HS   | issue ACK/NAK/STALL to usb_tx
// ST_SEND_DATA | issue DATA0/DATA1 (IN payload) to usb_tx
// ST_TX_WAIT   | usb_tx busy; wait for it to rise and then fall
// ST_WAIT_ACK  | IN data sent, waiting for the host handshake
module usb_protocol_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_transfer_active,
    input  logic       rx_error,
    input  logic       tx_data_ready,
    input  logic       ep_stall,
    input  logic       tx_busy,
    output logic [2:0] tx_packet,
    output logic       tx_start,
    output logic       d_mode,
    output logic       rx_commit,
    output logic       rx_discard,
    output logic       in_done,
    output logic       timeout_err
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_e     state;
    tx_pid_e    hs_pid;
    logic       out_toggle;
    logic       in_toggle;
    logic       busy_seen;
    logic       sent_data;
    logic       tmr_clear;
    logic       tmr_expired;
    logic [7:0] tmr_count;
    logic       data_timeout;
    logic       ack_timeout;

    // Only the two wait states run the timer, so any state change clears it
    assign tmr_clear    = !((state == ST_WAIT_DATA) || (state == ST_WAIT_ACK));
    assign data_timeout = tmr_expired && !rx_transfer_active;
    assign ack_timeout  = (tmr_count == LIMIT) && !rx_transfer_active;

    usb_timeout_counter u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (!rx_transfer_active),
        .limit   (LIMIT),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    // Transaction sequencing with registered command and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            hs_pid      <= TX_NONE;
            out_toggle  <= 1'b0;
            in_toggle   <= 1'b0;
            busy_seen   <= 1'b0;
            sent_data   <= 1'b0;
            tx_packet   <= TX_NONE;
            tx_start    <= 1'b0;
            d_mode      <= 1'b0;
            rx_commit   <= 1'b0;
            rx_discard  <= 1'b0;
            in_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            tx_packet   <= TX_NONE;
            rx_commit   <= 1'b0;
            rx_discard  <= 1'b0;
            in_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_data_ready && !rx_error) begin
                        if (rx_packet == RX_OUT) begin
                            state <= ST_WAIT_DATA;
                        end else if (rx_packet == RX_IN) begin
                            if (ep_stall) begin
                                hs_pid <= TX_STALL;
                                state  <= ST_SEND_HS;
                            end else if (tx_data_ready) begin
                                state  <= ST_SEND_DATA;
                            end else begin
                                hs_pid <= TX_NAK;
                                state  <= ST_SEND_HS;
                            end
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (rx_data_ready) begin
                        if (rx_error || !((rx_packet == RX_DATA0) || (rx_packet == RX_DATA1))) begin
                            rx_discard <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (ep_stall) begin
                            rx_discard <= 1'b1;
                            hs_pid     <= TX_STALL;
                            state      <= ST_SEND_HS;
                        end else begin
                            // Duplicate packets (toggle mismatch) are still ACKed
                            hs_pid <= TX_ACK;
                            state  <= ST_SEND_HS;
                            if ((rx_packet == RX_DATA1) == out_toggle) begin
                                rx_commit  <= 1'b1;
                                out_toggle <= ~out_toggle;
                            end else begin
                                rx_discard <= 1'b1;
                            end
                        end
                    end else if (data_timeout) begin
                        timeout_err <= 1'b1;
                        rx_discard  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_SEND_HS: begin
                    tx_start  <= 1'b1;
                    tx_packet <= hs_pid;
                    d_mode    <= 1'b1;
                    sent_data <= 1'b0;
                    busy_seen <= 1'b0;
                    state     <= ST_TX_WAIT;
                end
                ST_SEND_DATA: begin
                    tx_start  <= 1'b1;
                    tx_packet <= data_pid(in_toggle);
                    d_mode    <= 1'b1;
                    sent_data <= 1'b1;
                    busy_seen <= 1'b0;
                    state     <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tx_busy) begin
                        busy_seen <= 1'b1;
                    end else if (busy_seen) begin
                        d_mode <= 1'b0;
                        state  <= sent_data ? ST_WAIT_ACK : ST_IDLE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (rx_data_ready) begin
                        if ((rx_packet == RX_ACK) && !rx_error) begin
                            in_toggle <= ~in_toggle;
                            in_done   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (ack_timeout) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Directed and randomized transaction-level check of usb_protocol_ctrl.
module tb_usb_protocol_ctrl;

    localparam int TOUT = 162;
    // rx PID codes
    localparam int P_IN = 1, P_OUT = 2, P_DATA0 = 3, P_DATA1 = 4, P_ACK = 5, P_NAK = 6, P_STALL = 7;
    // tx PID codes
    localparam int T_DATA0 = 1, T_DATA1 = 2, T_ACK = 3, T_NAK = 4, T_STALL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx_packet = 3'd0;
    logic       rx_data_ready = 1'b0;
    logic       rx_transfer_active = 1'b0;
    logic       rx_error = 1'b0;
    logic       tx_data_ready = 1'b0;
    logic       ep_stall = 1'b0;
    logic       tx_busy = 1'b0;
    logic [2:0] tx_packet;
    logic       tx_start;
    logic       d_mode;
    logic       rx_commit;
    logic       rx_discard;
    logic       in_done;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int n_commit = 0, n_discard = 0, n_in_done = 0, n_tout = 0, n_tx = 0;
    int s_commit, s_discard, s_in_done, s_tout, s_tx;
    bit out_tog = 1'b0;
    bit in_tog  = 1'b0;

    always #5 clk = ~clk;

    usb_protocol_ctrl #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_packet          (rx_packet),
        .rx_data_ready      (rx_data_ready),
        .rx_transfer_active (rx_transfer_active),
        .rx_error           (rx_error),
        .tx_data_ready      (tx_data_ready),
        .ep_stall           (ep_stall),
        .tx_busy            (tx_busy),
        .tx_packet          (tx_packet),
        .tx_start           (tx_start),
        .d_mode             (d_mode),
        .rx_commit          (rx_commit),
        .rx_discard         (rx_discard),
        .in_done            (in_done),
        .timeout_err        (timeout_err)
    );

    // Pulse counters observed mid-cycle
    always @(negedge clk) begin
        if (rx_commit === 1'b1)   n_commit  = n_commit + 1;
        if (rx_discard === 1'b1)  n_discard = n_discard + 1;
        if (in_done === 1'b1)     n_in_done = n_in_done + 1;
        if (timeout_err === 1'b1) n_tout    = n_tout + 1;
        if (tx_start === 1'b1)    n_tx      = n_tx + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_rx(input int pid, input logic err);
        @(negedge clk);
        rx_packet     = 3'(pid);
        rx_error      = err;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        rx_packet     = 3'd0;
        rx_error      = 1'b0;
    endtask

    task automatic active_gap(input int n);
        if (n > 0) begin
            rx_transfer_active = 1'b1;
            repeat (n) @(negedge clk);
            rx_transfer_active = 1'b0;
        end
    endtask

    task automatic wait_tx(input string tag, input int exp_pid);
        int k = 0;
        while (tx_start !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_tx_seen"}, int'(tx_start), 1);
        check({tag, "_tx_pid"}, int'(tx_packet), exp_pid);
        check({tag, "_dmode_on"}, int'(d_mode), 1);
    endtask

    // tx_busy high for three cycles, optional stray packet while busy
    task automatic handshake(input string tag, input bit stray);
        @(negedge clk);
        tx_busy = 1'b1;
        @(negedge clk);
        if (stray) begin
            rx_packet     = 3'(P_ACK);
            rx_data_ready = 1'b1;
        end
        @(negedge clk);
        rx_data_ready = 1'b0;
        rx_packet     = 3'd0;
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        check({tag, "_dmode_off"}, int'(d_mode), 0);
    endtask

    task automatic snap();
        s_commit  = n_commit;
        s_discard = n_discard;
        s_in_done = n_in_done;
        s_tout    = n_tout;
        s_tx      = n_tx;
    endtask

    task automatic check_deltas(input string tag, input int c, input int d, input int i, input int t, input int x);
        repeat (3) @(negedge clk);
        check({tag, "_commit"}, n_commit - s_commit, c);
        check({tag, "_discard"}, n_discard - s_discard, d);
        check({tag, "_in_done"}, n_in_done - s_in_done, i);
        check({tag, "_timeout"}, n_tout - s_tout, t);
        check({tag, "_tx_count"}, n_tx - s_tx, x);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tx_packet"}, int'(tx_packet), 0);
        check({tag, "_pulses"}, int'({tx_start, d_mode, rx_commit, rx_discard, in_done, timeout_err}), 0);
    endtask

    initial begin
        int early;
        int fired;
        int kind, sel, pid, exp_pid, c, d, i, t, x;
        bit err, stray;

        // reset state and quiet release
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("release");

        // OUT + DATA0 with toggle 0: commit, ACK one cycle after SEND_HS entry
        pulse_rx(P_OUT, 1'b0);
        pulse_rx(P_DATA0, 1'b0);
        check("out0_commit", int'(rx_commit), 1);
        check("out0_tx_early", int'(tx_start), 0);
        @(negedge clk);
        check("out0_tx_latency", int'(tx_start), 1);
        wait_tx("out0", T_ACK);
        handshake("out0", 1'b0);
        out_tog = 1'b1;

        // duplicate DATA0: discard but still ACK
        pulse_rx(P_OUT, 1'b0);
        pulse_rx(P_DATA0, 1'b0);
        check("dup_discard", int'(rx_discard), 1);
        check("dup_commit", int'(rx_commit), 0);
        wait_tx("dup", T_ACK);
        handshake("dup", 1'b1);

        // toggle still 1: DATA1 commits
        pulse_rx(P_OUT, 1'b0);
        pulse_rx(P_DATA1, 1'b0);
        check("out1_commit", int'(rx_commit), 1);
        wait_tx("out1", T_ACK);
        handshake("out1", 1'b0);
        out_tog = 1'b0;

        // IN without data -> NAK, IN with stall -> STALL
        pulse_rx(P_IN, 1'b0);
        wait_tx("nak", T_NAK);
        handshake("nak", 1'b0);
        ep_stall = 1'b1;
        pulse_rx(P_IN, 1'b0);
        wait_tx("stall", T_STALL);
        handshake("stall", 1'b0);
        ep_stall = 1'b0;

        // push out_toggle to 1 before the reset test
        pulse_rx(P_OUT, 1'b0);
        pulse_rx(P_DATA0, 1'b0);
        wait_tx("pre_rst_out", T_ACK);
        handshake("pre_rst_out", 1'b0);

        // IN data, host ACK, next IN uses DATA1
        tx_data_ready = 1'b1;
        pulse_rx(P_IN, 1'b0);
        wait_tx("in0", T_DATA0);
        handshake("in0", 1'b0);
        pulse_rx(P_ACK, 1'b0);
        check("in0_done", int'(in_done), 1);
        pulse_rx(P_IN, 1'b0);
        wait_tx("in1", T_DATA1);
        handshake("in1", 1'b0);

        // host silent: timeout on cycle 162 of WAIT_ACK
        early = 0;
        fired = 0;
        for (int j = 1; j <= TOUT; j++) begin
            @(negedge clk);
            if (j < TOUT && timeout_err === 1'b1) early++;
            if (j == TOUT) fired = int'(timeout_err);
        end
        check("ack_tout_early", early, 0);
        check("ack_tout_at_162", fired, 1);
        check("ack_tout_dmode", int'(d_mode), 0);
        pulse_rx(P_IN, 1'b0);
        wait_tx("in_retry", T_DATA1);

        // reset while in TX_WAIT
        rst = 1'b1;
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("mid_release");
        out_tog = 1'b0;
        in_tog  = 1'b0;
        pulse_rx(P_IN, 1'b0);
        wait_tx("post_rst_in", T_DATA0);
        handshake("post_rst_in", 1'b0);
        pulse_rx(P_NAK, 1'b0);
        pulse_rx(P_OUT, 1'b0);
        pulse_rx(P_DATA0, 1'b0);
        check("post_rst_out_commit", int'(rx_commit), 1);
        wait_tx("post_rst_out", T_ACK);
        handshake("post_rst_out", 1'b0);
        out_tog = 1'b1;
        tx_data_ready = 1'b0;
        repeat (3) @(negedge clk);

        // randomized transactions against the toggle model
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            stray = bit'($urandom_range(0, 1));
            snap();
            c = 0; d = 0; i = 0; t = 0; x = 0;
            if (kind == 0) begin
                ep_stall = ($urandom_range(0, 3) == 0);
                pulse_rx(P_OUT, 1'b0);
                active_gap($urandom_range(0, 5));
                sel = $urandom_range(0, 9);
                if (sel == 9) begin
                    repeat (TOUT + 10) @(negedge clk);
                    d = 1; t = 1;
                end else begin
                    pid = (sel < 4) ? P_DATA0 : (sel < 8) ? P_DATA1 : P_ACK;
                    err = ($urandom_range(0, 7) == 0);
                    exp_pid = 0;
                    if (err || (pid != P_DATA0 && pid != P_DATA1)) begin
                        d = 1;
                    end else if (ep_stall) begin
                        d = 1; x = 1; exp_pid = T_STALL;
                    end else if (pid == (out_tog ? P_DATA1 : P_DATA0)) begin
                        c = 1; x = 1; exp_pid = T_ACK;
                        out_tog = ~out_tog;
                    end else begin
                        d = 1; x = 1; exp_pid = T_ACK;
                    end
                    pulse_rx(pid, err);
                    if (x == 1) begin
                        wait_tx("rnd_out", exp_pid);
                        handshake("rnd_out", stray);
                    end
                end
            end else if (kind == 1) begin
                ep_stall = ($urandom_range(0, 4) == 0);
                tx_data_ready = bit'($urandom_range(0, 1));
                pulse_rx(P_IN, 1'b0);
                x = 1;
                if (ep_stall) begin
                    wait_tx("rnd_in", T_STALL);
                    handshake("rnd_in", stray);
                end else if (!tx_data_ready) begin
                    wait_tx("rnd_in", T_NAK);
                    handshake("rnd_in", stray);
                end else begin
                    wait_tx("rnd_in", in_tog ? T_DATA1 : T_DATA0);
                    handshake("rnd_in", stray);
                    active_gap($urandom_range(0, 5));
                    sel = $urandom_range(0, 5);
                    if (sel <= 1) begin
                        pulse_rx(P_ACK, 1'b0);
                        i = 1;
                        in_tog = ~in_tog;
                    end else if (sel == 2) begin
                        pulse_rx(P_ACK, 1'b1);
                    end else if (sel == 3) begin
                        pulse_rx(P_NAK, 1'b0);
                    end else if (sel == 4) begin
                        pulse_rx(P_DATA0, 1'b0);
                    end else begin
                        repeat (TOUT + 8) @(negedge clk);
                        t = 1;
                    end
                end
            end else begin
                // packets that IDLE must ignore
                if ($urandom_range(0, 1) == 1) pulse_rx(($urandom_range(0, 1) == 1) ? P_IN : P_OUT, 1'b1);
                else pulse_rx($urandom_range(P_DATA0, P_STALL), bit'($urandom_range(0, 1)));
            end
            check_deltas("rnd", c, d, i, t, x);
            ep_stall = 1'b0;
            tx_data_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/usb_protocol_ctrl.md
USB_PROTOCOL_CTRL -- requirements
Module: usb_protocol_ctrl

Interface
REQ-001 Port: clk  input  1  system clock, 108 MHz, 9 cycles per full-speed bit.
REQ-002 Port: rst  input  1  asynchronous, active-high reset.
REQ-003 Port: rx_packet  input  3  decoded PID from usb_rx, valid only while rx_data_ready is high.
REQ-004 Port: rx_data_ready  input  1  one-cycle pulse after the EOP of a completed packet.
REQ-005 Port: rx_transfer_active  input  1  usb_rx is mid-packet.
REQ-006 Port: rx_error  input  1  usb_rx detected a bad packet; sampled at rx_data_ready.
REQ-007 Port: tx_data_ready  input  1  application holds a complete IN payload in the TX FIFO.
REQ-008 Port: ep_stall  input  1  endpoint halted.
REQ-009 Port: tx_busy  input  1  usb_tx is transmitting.
REQ-010 Port: tx_packet  output  3  PID command to usb_tx, valid while tx_start is high.
REQ-011 Port: tx_start  output  1  one-cycle transmit command.
REQ-012 Port: d_mode  output  1  high while the device owns the bus.
REQ-013 Port: rx_commit / rx_discard  output  1 each  one-cycle pulses that keep or drop the received OUT payload.
REQ-014 Port: in_done  output  1  one-cycle pulse when the host ACKs IN data.
REQ-015 Port: timeout_err  output  1  one-cycle pulse when the handshake wait expires.
REQ-016 Parameter: TIMEOUT_CYCLES, default 162, meaning cycles to wait for a host handshake (18 bit times).

Function
REQ-017 rx_packet encoding: 0 NONE, 1 IN, 2 OUT, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL.
REQ-018 tx_packet encoding: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL.
REQ-019 States: IDLE, WAIT_DATA, SEND_HS, SEND_DATA, TX_WAIT, WAIT_ACK.
REQ-020 IDLE: consume an rx_data_ready pulse with rx_error=0 as follows.
- OUT goes to WAIT_DATA.
- IN goes to SEND_HS with STALL if ep_stall=1.
- Otherwise IN goes to SEND_DATA if tx_data_ready=1.
- Otherwise IN goes to SEND_HS with NAK.
- Every other PID is ignored.
REQ-021 WAIT_DATA: on rx_data_ready, take one of these actions.
- rx_error=1: pulse rx_discard and return to IDLE with no response.
- PID not DATA0/1: pulse rx_discard and go to IDLE.
- ep_stall=1: pulse rx_discard and go to SEND_HS with STALL.
- PID matches out_toggle: pulse rx_commit, flip out_toggle, go to SEND_HS with ACK.
- PID mismatches out_toggle: pulse rx_discard, go to SEND_HS with ACK.
REQ-022 WAIT_DATA: if no packet arrives within TIMEOUT_CYCLES, pulse timeout_err and rx_discard and go to IDLE.
REQ-023 SEND_HS / SEND_DATA: assert tx_start for exactly one cycle with tx_packet set (SEND_DATA uses DATA0/DATA1 per in_toggle), then go to TX_WAIT; latency is one cycle from state entry.
REQ-024 TX_WAIT: wait for tx_busy to rise and then fall.
- After a handshake: go to IDLE.
- After data: go to WAIT_ACK.
REQ-025 WAIT_ACK: the counter starts at 0 and increments each cycle while rx_transfer_active=0.
- rx_data_ready with ACK and rx_error=0: flip in_toggle, pulse in_done, go to IDLE.
- Any other packet, or rx_error: go to IDLE with the toggle unchanged.
- Counter reaching TIMEOUT_CYCLES-1 with no transfer active: pulse timeout_err, go to IDLE, toggle unchanged.
REQ-026 The timeout counter is 8 bits wide, saturates rather than wrapping, and clears on every state change.
REQ-027 d_mode is high from tx_start through tx_busy falling, and low otherwise.
REQ-028 An rx_data_ready arriving in SEND_HS, SEND_DATA or TX_WAIT is ignored.
REQ-029 Simultaneous events: the rx_data_ready decision has priority over timeout expiry in the same cycle.
REQ-030 out_toggle and in_toggle are each 1 bit and reset to 0 (DATA0).

Reset
REQ-031 Asserting rst at any time, including mid-transaction, forces the following immediately.
- State to IDLE, toggles to 0, counter to 0.
- tx_packet=0 and tx_start, d_mode, rx_commit, rx_discard, in_done, timeout_err all 0.
- No pulse is emitted on reset release.

Structure
REQ-032 The rx_packet and tx_packet encodings, the state enum and the default TIMEOUT_CYCLES are kept in the shared package usb_pkg.
REQ-033 The timeout counter is a sub-module usb_timeout_counter with inputs clear, enable and limit, and outputs count and expired.

Verification
REQ-034 OUT, then DATA0 (out_toggle=0, no error) -> rx_commit pulse; tx_start with tx_packet=3 within 1 cycle of entering SEND_HS; out_toggle becomes 1.
REQ-035 OUT, then DATA0 again with out_toggle=1 -> rx_discard pulse and ACK sent (tx_packet=3); out_toggle stays 1.
REQ-036 IN with tx_data_ready=0 -> NAK (tx_packet=4). IN with ep_stall=1 -> STALL (tx_packet=5).
REQ-037 IN with tx_data_ready=1 -> DATA0 (tx_packet=1) sent; host ACK -> in_done pulse, in_toggle=1; the next IN sends DATA1 (tx_packet=2).
REQ-038 IN data sent, host silent -> timeout_err pulses on cycle 162 of WAIT_ACK; in_toggle unchanged; d_mode=0.
REQ-039 rst asserted while in TX_WAIT -> all outputs read 0 within the same cycle, and the next IN sends DATA0.
